// File: rtl/bringup_sequencer.sv
// Ordered board bring-up: VADJ PMBus, VADJ enable, FMC power-good, camera reset, SPI then I2C init.
// Optional wait-state timeout with FAULT state when BRINGUP_TIMEOUT_EN is defined.
module bringup_sequencer #(
  parameter logic [31:0] PMBUS_DELAY   = 32'd10000000,
  parameter logic [31:0] SETTLE_DELAY  = 32'd10000000,
  parameter logic [31:0] CAM_RST_DELAY = 32'd1000000,
  parameter logic [31:0] INIT_DELAY    = 32'd100000,
  parameter logic [31:0] TIMEOUT       = 32'd50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       restart,
  input  logic       pmbus_done,
  input  logic       spi_done,
  input  logic       i2c_done,
  output logic       pmbus_start,
  output logic       vadj_on,
  output logic       pg_c2m,
  output logic       cam_reset_n,
  output logic       spi_start,
  output logic       i2c_start,
  output logic       ready,
  output logic       error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_PM   = 4'd1,
    S_PM_START  = 4'd2,
    S_PM_WAIT   = 4'd3,
    S_SETTLE    = 4'd4,
    S_CAM_RST   = 4'd5,
    S_INIT_DLY  = 4'd6,
    S_SPI_START = 4'd7,
    S_SPI_WAIT  = 4'd8,
    S_I2C_START = 4'd9,
    S_I2C_WAIT  = 4'd10,
    S_DONE      = 4'd11,
    S_FAULT     = 4'd12
  } state_t;

  // Terminal count per timed state; a zero delay behaves as one cycle.
  localparam logic [31:0] PM_LAST     = (PMBUS_DELAY   == 32'd0) ? 32'd0 : PMBUS_DELAY   - 32'd1;
  localparam logic [31:0] SETTLE_LAST = (SETTLE_DELAY  == 32'd0) ? 32'd0 : SETTLE_DELAY  - 32'd1;
  localparam logic [31:0] CAM_LAST    = (CAM_RST_DELAY == 32'd0) ? 32'd0 : CAM_RST_DELAY - 32'd1;
  localparam logic [31:0] INIT_LAST   = (INIT_DELAY    == 32'd0) ? 32'd0 : INIT_DELAY    - 32'd1;

  state_t      r_state;
  logic [31:0] r_count;
  logic        r_pmbus_start;
  logic        r_vadj_on;
  logic        r_pg_c2m;
  logic        r_cam_reset_n;
  logic        r_spi_start;
  logic        r_i2c_start;
  logic        r_ready;
  logic        r_error;

  logic        w_in_wait;
  logic        w_wait_done;
  logic        w_timeout;

  assign w_in_wait   = (r_state == S_PM_WAIT) || (r_state == S_SPI_WAIT) || (r_state == S_I2C_WAIT);
  assign w_wait_done = ((r_state == S_PM_WAIT)  && pmbus_done) ||
                       ((r_state == S_SPI_WAIT) && spi_done)   ||
                       ((r_state == S_I2C_WAIT) && i2c_done);

`ifdef BRINGUP_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  assign w_timeout = (r_count == TO_LAST);
`else
  localparam logic [31:0] unused_timeout = TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_pmbus_start <= 1'b0;
      r_vadj_on     <= 1'b0;
      r_pg_c2m      <= 1'b0;
      r_cam_reset_n <= 1'b0;
      r_spi_start   <= 1'b0;
      r_i2c_start   <= 1'b0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_pmbus_start <= 1'b0;
      r_spi_start   <= 1'b0;
      r_i2c_start   <= 1'b0;
      r_count       <= r_count + 32'd1;
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT_PM;
          r_count <= '0;
        end
        S_WAIT_PM: if (r_count == PM_LAST) begin
          r_state       <= S_PM_START;
          r_pmbus_start <= 1'b1;
          r_count       <= '0;
        end
        S_PM_START: begin
          r_state <= S_PM_WAIT;
          r_count <= '0;
        end
        S_PM_WAIT: if (pmbus_done) begin
          r_state   <= S_SETTLE;
          r_vadj_on <= 1'b1;
          r_count   <= '0;
        end
        S_SETTLE: if (r_count == SETTLE_LAST) begin
          r_state  <= S_CAM_RST;
          r_pg_c2m <= 1'b1;
          r_count  <= '0;
        end
        S_CAM_RST: if (r_count == CAM_LAST) begin
          r_state       <= S_INIT_DLY;
          r_cam_reset_n <= 1'b1;
          r_count       <= '0;
        end
        S_INIT_DLY: if (r_count == INIT_LAST) begin
          r_state     <= S_SPI_START;
          r_spi_start <= 1'b1;
          r_count     <= '0;
        end
        S_SPI_START: begin
          r_state <= S_SPI_WAIT;
          r_count <= '0;
        end
        S_SPI_WAIT: if (spi_done) begin
          r_state     <= S_I2C_START;
          r_i2c_start <= 1'b1;
          r_count     <= '0;
        end
        S_I2C_START: begin
          r_state <= S_I2C_WAIT;
          r_count <= '0;
        end
        S_I2C_WAIT: if (i2c_done) begin
          r_state <= S_DONE;
          r_ready <= 1'b1;
          r_count <= '0;
        end
        S_DONE, S_FAULT: if (restart) begin
          r_state       <= S_IDLE;
          r_ready       <= 1'b0;
          r_error       <= 1'b0;
          r_vadj_on     <= 1'b0;
          r_pg_c2m      <= 1'b0;
          r_cam_reset_n <= 1'b0;
          r_count       <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the case so a timeout overrides the hold, but a same-cycle done still wins.
      if (w_in_wait && !w_wait_done && w_timeout) begin
        r_state       <= S_FAULT;
        r_error       <= 1'b1;
        r_vadj_on     <= 1'b0;
        r_pg_c2m      <= 1'b0;
        r_cam_reset_n <= 1'b0;
        r_ready       <= 1'b0;
        r_count       <= '0;
      end
    end
  end

  assign pmbus_start = r_pmbus_start;
  assign vadj_on     = r_vadj_on;
  assign pg_c2m      = r_pg_c2m;
  assign cam_reset_n = r_cam_reset_n;
  assign spi_start   = r_spi_start;
  assign i2c_start   = r_i2c_start;
  assign ready       = r_ready;
  assign error       = r_error;
  assign state       = r_state;

endmodule

// File: doc/bringup_sequencer.md
# bringup_sequencer

Power-up and initialization sequencer for the camera/display board. It replaces the free-running per-interface start timers with one ordered sequence: VADJ PMBus programming, VADJ enable, FMC power-good, VITA2000 reset release, then the VITA2000 SPI and ADV7511 I2C initializers, each gated on the previous step's completion. It sits in the top level on the system clock, between the serial initializers and the board and FMC control pins.

## Interface
Parameters:
- `PMBUS_DELAY`, 32'd10000000: cycles from reset release to the `pmbus_start` pulse.
- `SETTLE_DELAY`, 32'd10000000: cycles from `vadj_on` to `pg_c2m`.
- `CAM_RST_DELAY`, 32'd1000000: cycles from `pg_c2m` to `cam_reset_n` release.
- `INIT_DELAY`, 32'd100000: cycles from `cam_reset_n` release to `spi_start`.
- `TIMEOUT`, 32'd50000000: maximum wait for any `*_done` (used only when the macro is defined).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `restart` in 1: single-cycle request to rerun the sequence; honoured only in DONE or FAULT.
- `pmbus_done` in 1: VADJ PMBus initializer finished (level or pulse).
- `spi_done` in 1: VITA2000 SPI initializer finished.
- `i2c_done` in 1: ADV7511 I2C initializer finished.
- `pmbus_start` out 1: one-cycle start pulse to the PMBus initializer.
- `vadj_on` out 1: VADJ enable (top level drives `vadj_on_b = ~vadj_on`).
- `pg_c2m` out 1: FMC power good.
- `cam_reset_n` out 1: VITA2000 reset, active-low.
- `spi_start` out 1: one-cycle start pulse to the SPI master.
- `i2c_start` out 1: one-cycle start pulse to the HDMI I2C initializer.
- `ready` out 1: sequence complete.
- `error` out 1: sequence aborted by timeout.
- `state` out 4: current state encoding, for LEDs and debug.

## Operation
- States and encodings: IDLE 0, WAIT_PM 1, PM_START 2, PM_WAIT 3, SETTLE 4, CAM_RST 5, INIT_DLY 6, SPI_START 7, SPI_WAIT 8, I2C_START 9, I2C_WAIT 10, DONE 11, FAULT 12.
- IDLE → WAIT_PM on the first clock after reset.
- WAIT_PM holds `PMBUS_DELAY` cycles, then → PM_START.
- PM_START lasts one cycle with `pmbus_start`=1, then → PM_WAIT.
- PM_WAIT: on `pmbus_done`=1, set `vadj_on`=1 → SETTLE.
- SETTLE holds `SETTLE_DELAY` cycles, then sets `pg_c2m`=1 → CAM_RST.
- CAM_RST holds `CAM_RST_DELAY` cycles, then sets `cam_reset_n`=1 → INIT_DLY.
- INIT_DLY holds `INIT_DELAY` cycles, then → SPI_START.
- SPI_START is a one-cycle `spi_start` pulse, then → SPI_WAIT.
- SPI_WAIT: on `spi_done` → I2C_START.
- I2C_START is a one-cycle `i2c_start` pulse, then → I2C_WAIT.
- I2C_WAIT: on `i2c_done` → DONE.
- DONE: `ready`=1.
- Timed-state rules:
  - The 32-bit counter clears on state entry. The state exits when `count == DELAY-1`, so it lasts exactly DELAY cycles.
  - DELAY=0 behaves as 1.
- `*_done` handling:
  - Each `*_done` is sampled only in its own WAIT state.
  - A `*_done` asserted during the start-pulse cycle is ignored. The initializer must assert done no earlier than the cycle after its start.
  - Stale or early `*_done` outside the matching WAIT state has no effect.
- `vadj_on`, `pg_c2m` and `cam_reset_n` are sticky once set, until reset or restart.
- Restart:
  - `restart` in DONE or FAULT → IDLE.
  - `ready`, `error`, `vadj_on`, `pg_c2m` are cleared and `cam_reset_n` is driven 0 on the same edge.
  - `restart` in any other state is ignored.
- Reset mid-sequence: all outputs return to reset values immediately (asynchronously). The sequence restarts from IDLE after release.

## Timing
- Reset values:
  - All outputs 0 except `state`=0 (IDLE).
  - `cam_reset_n`=0, so the camera is held in reset.
- All outputs are registered; none are combinational from inputs.
- `pmbus_start` is high exactly 1 + `PMBUS_DELAY` + 1 cycles after reset release (IDLE, then the delay, then the registered pulse).
- Done-to-action latency is one cycle. Example: `vadj_on` rises on the edge that samples `pmbus_done`=1 in PM_WAIT.
- Start pulses are exactly one cycle wide and never overlap.

## Configuration
- `BRINGUP_TIMEOUT_EN` defined:
  - The counter also runs in PM_WAIT, SPI_WAIT and I2C_WAIT.
  - Reaching `TIMEOUT` cycles without done → FAULT. `error`=1, and the four power/reset/ready outputs are as in reset (`vadj_on`=0, `pg_c2m`=0, `cam_reset_n`=0, `ready`=0).
  - A done arriving in the same cycle as the timeout wins, i.e. the state advances.
- `BRINGUP_TIMEOUT_EN` undefined:
  - WAIT states wait indefinitely and FAULT is unreachable.
  - `error` is tied to 0, and the `TIMEOUT` parameter is unused.

## Test plan
All scenarios use delays of 4/3/2/2 and `TIMEOUT`=8.
- Nominal: release reset, return each done 3 cycles after its start → pulses and levels at the exact cycles, `state` walks 0..11, `ready`=1, `error`=0.
- Early and stale done: hold `spi_done`=1 from reset → no effect before SPI_WAIT. In SPI_WAIT the state advances one cycle after entry. Done asserted in a start cycle only is ignored.
- Reset in SETTLE with `vadj_on`=1 → all outputs 0 asynchronously, `cam_reset_n`=0. The sequence reruns with `pmbus_start` at cycle 6 after release.
- Restart: pulse `restart` in DONE → IDLE, `ready`=0, `cam_reset_n`=0, full sequence repeats. A `restart` pulse in SETTLE is ignored.
- With `BRINGUP_TIMEOUT_EN`, withhold `i2c_done` → FAULT after 8 cycles in I2C_WAIT, `error`=1, `pg_c2m`=0, `cam_reset_n`=0. A second run with done on cycle 8 → DONE.
- Without `BRINGUP_TIMEOUT_EN`, withhold `pmbus_done` for 1000 cycles → remains in PM_WAIT, `error`=0.
